// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types used by the fetch stage and the decoder.
package riscv_pkg;

    typedef logic [6:0] opcode_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam opcode_t OP_LOAD   = 7'h03;
    localparam opcode_t OP_STORE  = 7'h23;
    localparam opcode_t OP_R      = 7'h33;
    localparam opcode_t OP_I      = 7'h13;
    localparam opcode_t OP_BRANCH = 7'h63;
    localparam opcode_t OP_JAL    = 7'h6F;

    // Opcode field of a 32-bit instruction word.
    function automatic opcode_t get_opcode(input logic [31:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Registered instruction buffer with synchronous flush; no write-to-read bypass.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == DEPTH_W);
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && !empty && !flush;
        do_push_s = push && !flush && (!full || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, tagged buffering, redirect with stale-response drop.
// Optional build macro IFU_PERF_CNT_EN adds saturating pop/flush performance counters.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      op,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    rsp_pc_r;
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      drop_r;
    logic [CW-1:0]      inflight_next_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [XLEN+31:0]   fifo_head_s;
    logic [XLEN-1:0]    redirect_target_s;
    logic               req_fire_s;
    logic               push_s;
    logic               pop_s;

    // Request credit is a function of registered occupancy only.
    always_comb begin
        imem_req_valid    = ({1'b0, inflight_r} + {1'b0, fifo_count_s}) < DEPTH_W;
        imem_req_addr     = pc_r;
        req_fire_s        = imem_req_valid && imem_req_ready;
        redirect_target_s = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
        inflight_next_s   = inflight_r + {{(CW-1){1'b0}}, req_fire_s}
                                       - {{(CW-1){1'b0}}, imem_rsp_valid};
        push_s            = imem_rsp_valid && (drop_r == {CW{1'b0}}) && !redirect_valid
                            && (!fifo_full_s || pop_s);
    end

    // Decode-facing view of the buffer head; NOP with a zero PC when empty.
    always_comb begin
        instr_valid = !fifo_empty_s;
        pop_s       = instr_valid && !stall;
        if (instr_valid) begin
            instr    = fifo_head_s[31:0];
            instr_pc = fifo_head_s[XLEN+31:32];
        end else begin
            instr    = NOP_INSTR;
            instr_pc = {XLEN{1'b0}};
        end
        op = get_opcode(instr);
    end

    // Fetch PC, response tag PC, in-flight and drop counters. rsp_pc_r is the PC of the next kept response.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
        end else begin
            inflight_r <= inflight_next_s;
            if (redirect_valid) begin
                pc_r     <= redirect_target_s;
                rsp_pc_r <= redirect_target_s;
                drop_r   <= inflight_next_s;
            end else begin
                if (req_fire_s) begin
                    pc_r <= pc_r + PC_STEP;
                end
                if (imem_rsp_valid && (drop_r != {CW{1'b0}})) begin
                    drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + PC_STEP;
                end
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Saturating counters of delivered instructions and redirect cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'h0000_0000;
            perf_flush_cnt <= 32'h0000_0000;
        end else begin
            if (pop_s && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'h0000_0001;
            end
            if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'h0000_0001;
            end
        end
    end
`endif

    ifu_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data ({rsp_pc_r, imem_rsp_data}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the main decoder. It issues PC-sequential requests to instruction memory over a valid/ready request channel and buffers the returned words in a small FIFO. It presents one instruction per cycle, with its `op` field, to decode, and restarts the stream on a redirect from execute (jump or taken branch), discarding stale in-flight responses.

## Interface
- `XLEN`, 32: address/PC width.
- `RESET_PC`, 0: PC loaded on reset.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2; also the maximum requests in flight.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out XLEN: word-aligned fetch address.
- `imem_rsp_valid` in 1: response word valid; in request order; never back-pressured.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: restart fetch at `redirect_pc`.
- `redirect_pc` in XLEN: target; bits [1:0] ignored (forced 0).
- `stall` in 1: decode cannot take the instruction this cycle.
- `instr_valid` out 1: `instr`/`op`/`instr_pc` are valid.
- `instr` out 32: instruction word; `32'h0000_0013` (NOP) when `instr_valid`=0.
- `op` out 7: `instr[6:0]`, drives decoder `op`.
- `instr_pc` out XLEN: PC of `instr`.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: accepted requests not yet answered.
  - `drop`: responses still to discard.
  - FIFO: {pc, word} entries.
- Credit rule: `imem_req_valid = (inflight + fifo_count) < FIFO_DEPTH`. This value is purely register-derived and does not depend on `redirect_valid` or `stall`. A response can therefore never overflow the FIFO.
- Request handshake (`imem_req_valid && imem_req_ready`): `inflight`+1; `pc` += 4, with wrap modulo 2^XLEN.
- Response:
  - `inflight`−1.
  - If `drop`>0: `drop`−1 and the word is discarded.
  - Otherwise push {tag pc, word}. The tag pc is held in a parallel request-PC queue, or equivalently derived as the head PC plus 4×position.
- Pop: `instr_valid && !stall`.
- Redirect (highest priority):
  - `pc` ← `{redirect_pc[XLEN-1:2],2'b00}`.
  - FIFO flushed.
  - `drop` ← `inflight_next`, the in-flight count after this cycle's request and response.
  - A response arriving in the redirect cycle is discarded.
  - A request accepted in the redirect cycle is counted in `drop`.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Reset mid-operation:
  - All state is cleared and `drop`=0.
  - Responses arriving after reset for pre-reset requests are outside the contract. Memory must be reset together with this block.

## Timing
- Values after the first reset edge: `pc`=RESET_PC, `inflight`=0, `drop`=0, FIFO empty.
- Outputs after reset: `instr_valid`=0, `instr`=NOP, `op`=7'h13, `instr_pc`=0, `imem_req_valid`=1, `imem_req_addr`=RESET_PC.
- Latency: a response in cycle N gives `instr_valid`=1 in N+1. The FIFO is registered and has no bypass.
- Redirect in cycle N:
  - N+1: `instr_valid`=0 and `imem_req_addr`=target.
  - The first new instruction appears at the earliest one cycle after its response.
- Steady state: one instruction per cycle with single-cycle memory and `FIFO_DEPTH`≥2.
- `stall` holds `instr`/`op`/`instr_pc` stable.

## Configuration
- `IFU_PERF_CNT_EN` defined: adds outputs `perf_fetch_cnt` (32) and `perf_flush_cnt` (32).
  - `perf_fetch_cnt` counts pops.
  - `perf_flush_cnt` counts redirect cycles.
  - Both saturate at `32'hFFFF_FFFF` and reset to 0.
- Not defined: neither the ports nor the counters exist.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - Opcode constants: OP_LOAD 7'h03, OP_STORE 7'h23, OP_R 7'h33, OP_I 7'h13, OP_BRANCH 7'h63, OP_JAL 7'h6F.
  - `opcode_t` typedef for `logic [6:0]`.
- One sub-module: `ifu_fifo`.
  - Parameterised width and depth; synchronous flush; push, pop, full, empty, count.

## Test plan
- Reset, `imem_req_ready`=1, 1-cycle memory returning `addr` as data: `instr_pc`/`instr` = 0, 4, 8, … one per cycle; `op`=`instr[6:0]`.
- `imem_req_ready`=0 for 10 cycles after reset: `imem_req_valid` stays 1, `imem_req_addr` stays RESET_PC, `instr_valid`=0.
- `stall`=1 with FIFO filling: at most `FIFO_DEPTH` requests outstanding plus buffered, `imem_req_valid`=0 when full, outputs stable; release `stall` and the sequence continues with no gaps or duplicates.
- Redirect to 0x100 with 2 requests in flight (3-cycle memory latency): both stale words dropped; the next `instr_valid` shows `instr_pc`=0x100.
- Redirect to 0x103 in the same cycle as a response and a request handshake: the response is discarded, the accepted request's response is dropped, and fetch resumes at 0x100.
- `pc`=0xFFFF_FFFC with a sequential fetch: the next address wraps to 0x0. With `IFU_PERF_CNT_EN`, the counters match scoreboard totals.
